// File: rtl/dehaze_frame_ctrl.sv
// Frame sequencer ahead of the dark-channel min filter: qualifies frames,
// gates video timing, tracks pixel position and checks frame geometry.
module dehaze_frame_ctrl #(
  parameter int PIC_WIDTH  = 640,
  parameter int PIC_HEIGHT = 480,
  parameter int CNT_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pre_frame_vsync,
  input  logic             pre_frame_href,
  input  logic             pre_frame_clken,
  input  logic             cfg_enable,
  input  logic             cfg_bypass,
  input  logic             err_clr,
  output logic             filt_frame_vsync,
  output logic             filt_frame_href,
  output logic             filt_frame_clken,
  output logic             bypass_sel,
  output logic [CNT_W-1:0] pix_col,
  output logic [CNT_W-1:0] pix_row,
  output logic             edge_flag,
  output logic             frame_busy,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic             err_line_len,
  output logic             err_frame_h
);

  typedef enum logic {IDLE, FRAME} state_t;

  localparam logic [CNT_W-1:0] W_C = CNT_W'(PIC_WIDTH);
  localparam logic [CNT_W-1:0] H_C = CNT_W'(PIC_HEIGHT);
  localparam logic [CNT_W-1:0] W_L = CNT_W'(PIC_WIDTH - 1);
  localparam logic [CNT_W-1:0] H_L = CNT_W'(PIC_HEIGHT - 1);
  localparam logic [CNT_W-1:0] C_MAX = '1;

  state_t state, state_nxt;

  logic vsync_d, href_d;
  logic vs_rise, vs_fall, hs_fall;
  logic pix, enter, active, in_frame;
  logic line_err, frame_end, height_ok;
  logic is_edge;
  logic [CNT_W-1:0] col_cnt, row_cnt;
  logic [CNT_W-1:0] col_base, row_base;
  logic [CNT_W-1:0] col_nxt, row_nxt;

  assign vs_rise = pre_frame_vsync & ~vsync_d;
  assign vs_fall = ~pre_frame_vsync & vsync_d;
  assign hs_fall = ~pre_frame_href & href_d;
  assign pix     = pre_frame_href & pre_frame_clken;

  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
    unique case (state)
      IDLE: begin
        if (vs_rise && cfg_enable) begin
          state_nxt = FRAME;
          enter     = 1'b1;
        end
      end
      FRAME: begin
        if (vs_fall) state_nxt = IDLE;
      end
    endcase
  end

  assign in_frame = (state == FRAME);
  assign active   = in_frame | enter;

  // Clears take effect on the same cycle so the first pixel reads as 0.
  always_comb begin
    col_base = (vs_rise | hs_fall) ? '0 : col_cnt;
    row_base = vs_rise ? '0 : row_cnt;
    col_nxt  = col_base;
    row_nxt  = row_base;
    if (pix && col_base != C_MAX) col_nxt = col_base + 1'b1;
    if (hs_fall && row_base != C_MAX) row_nxt = row_base + 1'b1;
  end

  assign line_err  = in_frame & hs_fall & (col_cnt != W_C);
  assign frame_end = in_frame & vs_fall;
  assign height_ok = (row_nxt == H_C);
  assign is_edge   = (row_base == '0) | (row_base == H_L) |
                     (col_base == '0) | (col_base == W_L);

  assign frame_busy = in_frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      vsync_d          <= 1'b1;
      href_d           <= 1'b0;
      col_cnt          <= '0;
      row_cnt          <= '0;
      filt_frame_vsync <= 1'b0;
      filt_frame_href  <= 1'b0;
      filt_frame_clken <= 1'b0;
      bypass_sel       <= 1'b0;
      pix_col          <= '0;
      pix_row          <= '0;
      edge_flag        <= 1'b0;
      frame_done       <= 1'b0;
      frame_cnt        <= '0;
      err_line_len     <= 1'b0;
      err_frame_h      <= 1'b0;
    end else begin
      state            <= state_nxt;
      vsync_d          <= pre_frame_vsync;
      href_d           <= pre_frame_href;
      col_cnt          <= col_nxt;
      row_cnt          <= row_nxt;
      filt_frame_vsync <= active & pre_frame_vsync;
      filt_frame_href  <= active & pre_frame_href;
      filt_frame_clken <= active & pre_frame_clken;
      if (enter) bypass_sel <= cfg_bypass;
      if (!active) pix_col <= '0;
      else if (pix) pix_col <= col_base;
      pix_row    <= active ? row_base : '0;
      edge_flag  <= active & pix & is_edge;
      frame_done <= frame_end & height_ok;
      if (frame_end && height_ok) frame_cnt <= frame_cnt + 16'd1;
      if (line_err) err_line_len <= 1'b1;
      else if (err_clr) err_line_len <= 1'b0;
      if (frame_end && !height_ok) err_frame_h <= 1'b1;
      else if (err_clr) err_frame_h <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dehaze_frame_ctrl.sv
// Randomized frame-level bench for dehaze_frame_ctrl against a frame model
// built from line/frame descriptions (8x4 picture).
module tb_dehaze_frame_ctrl;

  localparam int W = 8;
  localparam int H = 4;
  localparam int CW = 12;
  localparam int EV_NONE = 0;
  localparam int EV_RISE = 1;
  localparam int EV_HS = 2;
  localparam int EV_VS = 3;

  logic clk = 1'b0;
  logic rst;
  logic pre_frame_vsync, pre_frame_href, pre_frame_clken;
  logic cfg_enable, cfg_bypass, err_clr;
  logic filt_frame_vsync, filt_frame_href, filt_frame_clken;
  logic bypass_sel, edge_flag, frame_busy, frame_done;
  logic [CW-1:0] pix_col, pix_row;
  logic [15:0] frame_cnt;
  logic err_line_len, err_frame_h;

  int checks = 0;
  int errors = 0;

  bit byp_m, err_l_m, err_h_m, cur_byp, tog;
  int cnt_m, cur_len, cur_lines, ecnt;

  dehaze_frame_ctrl #(
    .PIC_WIDTH(W),
    .PIC_HEIGHT(H),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pre_frame_vsync(pre_frame_vsync),
    .pre_frame_href(pre_frame_href),
    .pre_frame_clken(pre_frame_clken),
    .cfg_enable(cfg_enable),
    .cfg_bypass(cfg_bypass),
    .err_clr(err_clr),
    .filt_frame_vsync(filt_frame_vsync),
    .filt_frame_href(filt_frame_href),
    .filt_frame_clken(filt_frame_clken),
    .bypass_sel(bypass_sel),
    .pix_col(pix_col),
    .pix_row(pix_row),
    .edge_flag(edge_flag),
    .frame_busy(frame_busy),
    .frame_done(frame_done),
    .frame_cnt(frame_cnt),
    .err_line_len(err_line_len),
    .err_frame_h(err_frame_h)
  );

  always #5 clk = ~clk;

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_fvs"}, 32'(filt_frame_vsync), 0);
    chk({pfx, "_fhs"}, 32'(filt_frame_href), 0);
    chk({pfx, "_fck"}, 32'(filt_frame_clken), 0);
    chk({pfx, "_byp"}, 32'(bypass_sel), 0);
    chk({pfx, "_col"}, 32'(pix_col), 0);
    chk({pfx, "_row"}, 32'(pix_row), 0);
    chk({pfx, "_edge"}, 32'(edge_flag), 0);
    chk({pfx, "_busy"}, 32'(frame_busy), 0);
    chk({pfx, "_done"}, 32'(frame_done), 0);
    chk({pfx, "_cnt"}, 32'(frame_cnt), 0);
    chk({pfx, "_errl"}, 32'(err_line_len), 0);
    chk({pfx, "_errh"}, 32'(err_frame_h), 0);
  endtask

  // One clock of stimulus; act says whether this cycle belongs to an
  // accepted frame, ev marks frame start / line end / frame end.
  task automatic step(input bit vs, input bit hs, input bit ck,
                      input bit act, input int r, input int c,
                      input int ev);
    bit pixel, set_l, set_h, done_e, e_exp;
    pre_frame_vsync = vs;
    pre_frame_href  = hs;
    pre_frame_clken = ck;
    if (tog) cfg_bypass = rb();
    @(posedge clk);
    #1;
    pixel  = act && hs && ck;
    set_l  = (ev == EV_HS) && act && (cur_len != W);
    set_h  = (ev == EV_VS) && act && (cur_lines != H);
    done_e = (ev == EV_VS) && act && (cur_lines == H);
    if (ev == EV_RISE && act) byp_m = cur_byp;
    err_l_m = set_l ? 1'b1 : (err_clr ? 1'b0 : err_l_m);
    err_h_m = set_h ? 1'b1 : (err_clr ? 1'b0 : err_h_m);
    if (done_e) cnt_m = (cnt_m + 1) % 65536;
    chk("fvs", 32'(filt_frame_vsync), 32'(act && vs));
    chk("fhs", 32'(filt_frame_href), 32'(act && hs));
    chk("fck", 32'(filt_frame_clken), 32'(act && ck));
    chk("busy", 32'(frame_busy), 32'(act && vs));
    chk("done", 32'(frame_done), 32'(done_e));
    chk("cnt", 32'(frame_cnt), 32'(cnt_m));
    chk("byp", 32'(bypass_sel), 32'(byp_m));
    chk("errl", 32'(err_line_len), 32'(err_l_m));
    chk("errh", 32'(err_frame_h), 32'(err_h_m));
    if (pixel) begin
      e_exp = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
      chk("col", 32'(pix_col), 32'(c));
      chk("row", 32'(pix_row), 32'(r));
      chk("edge", 32'(edge_flag), 32'(e_exp));
      if (edge_flag === 1'b1) ecnt++;
    end else begin
      chk("edge0", 32'(edge_flag), 0);
    end
  endtask

  task automatic send_frame(input bit en, input bit byp, input bit dense,
                            input bit tg, input int nl, input int srow,
                            input int slen);
    int len, c, g;
    bit ck;
    cfg_enable = en;
    cfg_bypass = byp;
    cur_byp = byp;
    tog = 1'b0;
    ecnt = 0;
    repeat (3) step(0, 0, rb(), 0, 0, 0, EV_NONE);
    step(1, 0, dense | rb(), en, 0, 0, EV_RISE);
    step(1, 0, dense | rb(), en, 0, 0, EV_NONE);
    for (int r = 0; r < nl; r++) begin
      len = (r == srow) ? slen : W;
      c = 0;
      while (c < len) begin
        ck = dense | ($urandom_range(0, 3) != 0);
        step(1, 1, ck, en, r, c, EV_NONE);
        if (ck) c++;
      end
      cur_len = len;
      g = dense ? 3 : 2 + $urandom_range(0, 2);
      for (int k = 0; k < g; k++)
        step(1, 0, dense | rb(), en, 0, 0, (k == 0) ? EV_HS : EV_NONE);
      if (tg && r == 0) begin
        cfg_enable = 1'b1;
        tog = 1'b1;
      end
    end
    cur_lines = nl;
    step(0, 0, dense | rb(), en, 0, 0, EV_VS);
    tog = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pre_frame_vsync = 1'b0;
    pre_frame_href = 1'b0;
    pre_frame_clken = 1'b0;
    cfg_enable = 1'b0;
    cfg_bypass = 1'b0;
    err_clr = 1'b0;
    tog = 1'b0;
    byp_m = 1'b0;
    err_l_m = 1'b0;
    err_h_m = 1'b0;
    cnt_m = 0;
    cur_len = W;
    cur_lines = H;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    rst = 1'b0;

    // nominal dense frame
    send_frame(1, 0, 1, 0, H, -1, W);
    chk("edge_total", 32'(ecnt), 20);
    chk("cnt_f1", 32'(frame_cnt), 1);

    // disabled at start, enable raised mid-frame, then an accepted frame
    send_frame(0, 1, 0, 1, H, -1, W);
    send_frame(1, 0, 0, 0, H, -1, W);

    // short line 2; clear; short line while clear held
    send_frame(1, 1, 0, 0, H, 1, 7);
    err_clr = 1'b1;
    step(0, 0, 0, 0, 0, 0, EV_NONE);
    err_clr = 1'b0;
    send_frame(1, 0, 0, 0, H, 2, 7);
    err_clr = 1'b1;
    send_frame(1, 0, 0, 0, H, 1, 5);
    err_clr = 1'b0;
    step(0, 0, 0, 0, 0, 0, EV_NONE);

    // short frame
    send_frame(1, 0, 0, 0, 3, -1, W);
    err_clr = 1'b1;
    step(0, 0, 0, 0, 0, 0, EV_NONE);
    err_clr = 1'b0;

    // bypass latched and stable against toggling; next frame drops it
    send_frame(1, 1, 0, 1, H, -1, W);
    send_frame(1, 0, 0, 0, H, -1, W);
    send_frame(0, 1, 0, 0, H, -1, W);

    // reset in the middle of line 1, released while vsync high
    cfg_enable = 1'b1;
    cfg_bypass = 1'b1;
    cur_byp = 1'b1;
    repeat (2) step(0, 0, 0, 0, 0, 0, EV_NONE);
    step(1, 0, 0, 1, 0, 0, EV_RISE);
    step(1, 0, 0, 1, 0, 0, EV_NONE);
    for (int c = 0; c < 4; c++) step(1, 1, 1, 1, 0, c, EV_NONE);
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    byp_m = 1'b0;
    cnt_m = 0;
    err_l_m = 1'b0;
    err_h_m = 1'b0;
    for (int c = 0; c < 2; c++) step(1, 1, 1, 0, 0, 0, EV_NONE);
    rst = 1'b0;
    for (int k = 0; k < 12; k++)
      step(1, (k % 4) != 3, 1, 0, 0, 0, EV_NONE);
    send_frame(1, 0, 0, 0, H, -1, W);
    chk("cnt_after_rst", 32'(frame_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dehaze_frame_ctrl.md
Name: dehaze_frame_ctrl

Overview:
- Frame-level sequencer in front of the 3x3 dark-channel minimum filter and the downstream dehaze stages.
- Qualifies each incoming frame against per-frame configuration latched at frame start, and gates the video timing into the filter. The configuration is enable plus bypass.
- Tracks row/column position and flags window-edge pixels for border handling.
- Checks line length and frame height; reports frame completion and sticky errors.

Parameters:
PIC_WIDTH, 640, active pixels per line
PIC_HEIGHT, 480, active lines per frame
CNT_W, 12, width of row/column counters (must hold PIC_WIDTH and PIC_HEIGHT)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
pre_frame_vsync  in  1  frame valid, high for the whole frame
pre_frame_href  in  1  line valid
pre_frame_clken  in  1  pixel strobe
cfg_enable  in  1  process frames; sampled only at frame start
cfg_bypass  in  1  route raw video past the filter; sampled only at frame start
err_clr  in  1  clears sticky errors
filt_frame_vsync  out  1  gated vsync to the filter
filt_frame_href  out  1  gated href to the filter
filt_frame_clken  out  1  gated clken to the filter
bypass_sel  out  1  latched bypass for the current frame
pix_col  out  CNT_W  column index of the pixel on filt_frame_clken
pix_row  out  CNT_W  row index of the current line
edge_flag  out  1  pixel is in row 0, last row, col 0 or last col
frame_busy  out  1  high while in FRAME state
frame_done  out  1  one-cycle pulse at end of an accepted frame
frame_cnt  out  16  accepted-frame count, wraps
err_line_len  out  1  sticky: a line length was not equal to PIC_WIDTH
err_frame_h  out  1  sticky: a frame height was not equal to PIC_HEIGHT

Behaviour:
- Reset is asynchronous on rst rising and releases synchronously.
  - All outputs reset to 0; state resets to IDLE.
  - The internal vsync_d register resets to 1. A frame start is recognized only after vsync has been seen low, so no false start occurs when reset releases mid-frame.
- Edge detect uses 1-cycle delayed copies of vsync and href.
  - vs_rise = vsync & ~vsync_d
  - vs_fall = ~vsync & vsync_d
  - hs_fall = ~href & href_d
- FSM states are IDLE and FRAME.
  - IDLE, on vs_rise: latch cfg_enable and cfg_bypass. Go to FRAME if cfg_enable=1; otherwise stay in IDLE, skip the whole frame, and keep filt_* at 0.
  - FRAME, on vs_fall: go to IDLE.
    - If row count equals PIC_HEIGHT: pulse frame_done and increment frame_cnt.
    - Otherwise: set err_frame_h, and do not pulse frame_done.
  - vs_rise while in FRAME cannot occur, because vsync must fall first.
- Gating and latency:
  - filt_frame_* equal the inputs delayed by exactly 1 clk when in FRAME or on the vs_rise cycle that enters FRAME. Otherwise they are 0.
  - filt_frame_vsync falls 1 cycle after the input falls.
  - bypass_sel holds its value from frame start until the next accepted frame start.
- Counters:
  - The column counter increments on href&clken and is cleared on hs_fall and on vs_rise.
  - pix_col is registered with filt_frame_clken and carries the pre-increment value, so the first pixel of a line is 0.
  - The row counter increments on hs_fall and is cleared on vs_rise. pix_row is the row of the pixel currently output.
  - Both counters saturate at 2^CNT_W-1; they never wrap.
  - A length check runs on hs_fall: if the column count is not equal to PIC_WIDTH, set err_line_len.
  - clken pulses while href is low are ignored.
- edge_flag is valid only with filt_frame_clken and is 0 otherwise. It is set when the output pixel has pix_row==0, pix_row==PIC_HEIGHT-1, pix_col==0 or pix_col==PIC_WIDTH-1.
- Errors:
  - Errors are sticky until err_clr.
  - If err_clr coincides with a new error event, the error stays set (set wins).
  - Errors are only evaluated in FRAME.
- frame_cnt wraps from 0xFFFF to 0.
- Changes to cfg_* while in FRAME have no effect until the next vs_rise.
- Reset asserted mid-frame behaves as follows:
  - Outputs drop to 0 immediately.
  - The partial frame is discarded, with no frame_done pulse and no error flag.
  - Processing resumes at the next full vsync low-to-high transition.

Test Plan:
1. Test a nominal frame at PIC_WIDTH=8, PIC_HEIGHT=4, cfg_enable=1, with clken every cycle and a 3-cycle href gap.
   - filt_* equal the inputs delayed 1 cycle.
   - pix_col runs 0..7 and pix_row runs 0..3.
   - edge_flag is 1 on 20 of the 32 pixels.
   - frame_done pulses once, 1 cycle after vsync falls; frame_cnt=1; no errors.
2. Set cfg_enable=0 at vs_rise, then raise it to 1 mid-frame.
   - filt_* stay 0 for the whole frame; no frame_done; frame_cnt unchanged.
   - The next frame is accepted.
3. Send line 2 with 7 pixels.
   - err_line_len sets on that hs_fall; frame_done still pulses (height ok).
   - err_clr clears err_line_len; holding err_clr together with another short line leaves it at 1.
4. Send a frame of 3 lines.
   - err_frame_h sets; no frame_done; frame_cnt unchanged.
5. Assert rst in the middle of line 1, then release it while vsync is high.
   - All outputs go to 0; no activity until vsync goes low and then high again.
   - The following full frame completes with frame_cnt=1.
6. Set cfg_bypass=1 at frame start and toggle it during the frame.
   - bypass_sel=1 for the whole frame.
   - In the next frame, started with cfg_bypass=0, bypass_sel goes to 0 at its vs_rise+1.
